// File: rtl/genius_seq_gen_pkg.sv
// Shared types and constants for the Genius sequence engine:
// FSM encodings, default geometry and the LFSR feedback.
package genius_seq_gen_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_GUESS = 2'd2
    } state_t;

    localparam int          DEF_N_COLORS = 4;
    localparam int          DEF_MAX_LEN  = 16;
    localparam logic [15:0] DEF_SEED     = 16'hACE1;

    // Galois mask for x^16+x^14+x^13+x^11+1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/genius_seq_gen_if.sv
// Controller/IO-side bundle of the sequence engine; master drives commands,
// slave (the engine) drives playback and result pulses.
interface genius_seq_gen_if
    import genius_seq_gen_pkg::*;
#(
    parameter int N_COLORS = DEF_N_COLORS,
    parameter int MAX_LEN  = DEF_MAX_LEN
);
    localparam int LW = $clog2(MAX_LEN) + 1;

    logic                mode;
    logic                new_game;
    logic                extend;
    logic                play;
    logic                tick;
    logic                guess_valid;
    logic [N_COLORS-1:0] guess;
    logic [N_COLORS-1:0] color_out;
    logic                play_busy;
    logic                play_done;
    logic                match;
    logic                mismatch;
    logic                round_done;
    logic [LW-1:0]       seq_len;
    logic                full;

    modport master (
        output mode, new_game, extend, play, tick, guess_valid, guess,
        input  color_out, play_busy, play_done, match, mismatch, round_done,
               seq_len, full
    );

    modport slave (
        input  mode, new_game, extend, play, tick, guess_valid, guess,
        output color_out, play_busy, play_done, match, mismatch, round_done,
               seq_len, full
    );

endinterface

// File: rtl/genius_seq_gen_lfsr.sv
// Free-running 16-bit Galois LFSR; runs every cycle so player timing
// decides which value a new element picks up.
module genius_lfsr
    import genius_seq_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= SEED;
        else     q <= lfsr_step(q);
    end

endmodule

// File: rtl/genius_seq_gen.sv
// Genius sequence engine: run-time-length sequence store, fixed/random fill,
// tick-paced playback and guess checking. All outputs are registered.
module genius_seq_gen
    import genius_seq_gen_pkg::*;
#(
    parameter int          N_COLORS = DEF_N_COLORS,
    parameter int          MAX_LEN  = DEF_MAX_LEN,
    parameter logic [15:0] SEED     = DEF_SEED
) (
    input  logic            clk,
    input  logic            rst,
    genius_seq_gen_if.slave bus
);

    localparam int CW = $clog2(N_COLORS);
    localparam int IW = $clog2(MAX_LEN);
    localparam int LW = IW + 1;
    localparam logic [LW-1:0] LEN_ONE = LW'(1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    function automatic logic [N_COLORS-1:0] onehot(input logic [CW-1:0] i);
        return N_COLORS'(1) << i;
    endfunction

    state_t                      state_q, state_n;
    logic [IW-1:0]               idx_q, idx_n, gidx_q, gidx_n;
    logic [LW-1:0]               len_q, len_n, last;
    logic [MAX_LEN-1:0][CW-1:0]  mem;
    logic                        wr_en;
    logic [IW-1:0]               wr_idx;
    logic [CW-1:0]               new_col;
    logic [15:0]                 lfsr_q;
    logic                        unused_lfsr;

    logic [N_COLORS-1:0] color_q, color_n;
    logic busy_q, done_q, done_n, match_q, match_n, mism_q, mism_n, rdone_q, rdone_n;
    logic full_q;

    genius_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr_q));

    assign unused_lfsr = ^lfsr_q[15:CW];
    assign new_col     = bus.mode ? lfsr_q[CW-1:0] : '0;
    assign last        = len_q - LEN_ONE;

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        gidx_n  = gidx_q;
        len_n   = len_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        done_n  = 1'b0;
        match_n = 1'b0;
        mism_n  = 1'b0;
        rdone_n = 1'b0;
        if (bus.new_game) begin
            state_n = S_IDLE;
            wr_en   = 1'b1;
            len_n   = LEN_ONE;
            idx_n   = '0;
            gidx_n  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // extend wins over a same-cycle play
                    if (bus.extend) begin
                        if (len_q != LEN_MAX) begin
                            wr_en  = 1'b1;
                            wr_idx = len_q[IW-1:0];
                            len_n  = len_q + LEN_ONE;
                        end
                    end else if (bus.play && len_q != '0) begin
                        state_n = S_PLAY;
                        idx_n   = '0;
                    end
                end
                S_PLAY: begin
                    if (bus.tick) begin
                        if ({1'b0, idx_q} == last) begin
                            done_n  = 1'b1;
                            state_n = S_GUESS;
                            gidx_n  = '0;
                        end else begin
                            idx_n = idx_q + IW'(1);
                        end
                    end
                end
                S_GUESS: begin
                    if (bus.guess_valid) begin
                        // onehot() is always one-hot, so malformed guesses fall to mismatch
                        if (bus.guess == onehot(mem[gidx_q])) begin
                            match_n = 1'b1;
                            if ({1'b0, gidx_q} == last) begin
                                rdone_n = 1'b1;
                                state_n = S_IDLE;
                            end else begin
                                gidx_n = gidx_q + IW'(1);
                            end
                        end else begin
                            mism_n  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        color_n = (state_n == S_PLAY) ? onehot(mem[idx_n]) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            gidx_q  <= '0;
            len_q   <= '0;
            mem     <= '0;
            color_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            mism_q  <= 1'b0;
            rdone_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            gidx_q  <= gidx_n;
            len_q   <= len_n;
            if (wr_en) mem[wr_idx] <= new_col;
            color_q <= color_n;
            busy_q  <= (state_n == S_PLAY);
            done_q  <= done_n;
            match_q <= match_n;
            mism_q  <= mism_n;
            rdone_q <= rdone_n;
            full_q  <= (len_n == LEN_MAX);
        end
    end

    assign bus.color_out  = color_q;
    assign bus.play_busy  = busy_q;
    assign bus.play_done  = done_q;
    assign bus.match      = match_q;
    assign bus.mismatch   = mism_q;
    assign bus.round_done = rdone_q;
    assign bus.seq_len    = len_q;
    assign bus.full       = full_q;

endmodule

// File: tb/tb_genius_seq_gen.sv
// Directed bench for genius_seq_gen: fixed fill, playback, guessing, full,
// LFSR-random fill against a reference LFSR, and async reset mid-playback.
module tb_genius_seq_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   npass = 0;
    int   ntot  = 0;
    logic [15:0] m_lfsr;
    logic [1:0]  expc [16];

    genius_seq_gen_if #(.N_COLORS(4), .MAX_LEN(16)) bus ();

    genius_seq_gen #(.N_COLORS(4), .MAX_LEN(16), .SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    // reference LFSR for x^16+x^14+x^13+x^11+1, running in lockstep with the DUT
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        chk("play_done", 32'(bus.play_done), 0);
        chk("match",     32'(bus.match), 0);
        chk("mismatch",  32'(bus.mismatch), 0);
        chk("round_done",32'(bus.round_done), 0);
    endtask

    task automatic do_new_game(input logic m);
        bus.mode = m; bus.new_game = 1'b1; cyc(); bus.new_game = 1'b0;
    endtask

    task automatic do_extend();
        bus.extend = 1'b1; cyc(); bus.extend = 1'b0;
    endtask

    task automatic do_play();
        bus.play = 1'b1; cyc(); bus.play = 1'b0;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1; cyc(); bus.tick = 1'b0;
    endtask

    task automatic do_guess(input logic [3:0] g);
        bus.guess = g; bus.guess_valid = 1'b1; cyc(); bus.guess_valid = 1'b0; bus.guess = '0;
    endtask

    initial begin
        bus.mode = 0; bus.new_game = 0; bus.extend = 0; bus.play = 0;
        bus.tick = 0; bus.guess_valid = 0; bus.guess = '0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst seq_len", 32'(bus.seq_len), 0);
        chk("rst full",    32'(bus.full), 0);
        chk("rst color",   32'(bus.color_out), 0);
        chk("rst busy",    32'(bus.play_busy), 0);
        quiet();
        rst = 1'b0;
        cyc();

        // fixed mode: 1 + 3 elements, play back four colour-0 steps
        do_new_game(1'b0);
        chk("ng seq_len", 32'(bus.seq_len), 1);
        for (int i = 0; i < 3; i++) do_extend();
        chk("ext seq_len", 32'(bus.seq_len), 4);
        do_play();
        chk("play busy",  32'(bus.play_busy), 1);
        chk("play color", 32'(bus.color_out), 32'h1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            chk("step color", 32'(bus.color_out), 32'h1);
            chk("step done",  32'(bus.play_done), 0);
        end
        do_tick();
        chk("last done",  32'(bus.play_done), 1);
        chk("last color", 32'(bus.color_out), 0);
        chk("last busy",  32'(bus.play_busy), 0);
        cyc();
        chk("done pulse", 32'(bus.play_done), 0);

        // tick in GUESS ignored; then match, then mismatch with 0010
        do_tick();
        quiet();
        do_guess(4'b0001);
        chk("g1 match", 32'(bus.match), 1);
        chk("g1 rdone", 32'(bus.round_done), 0);
        do_guess(4'b0010);
        chk("g2 mismatch", 32'(bus.mismatch), 1);
        chk("g2 match",    32'(bus.match), 0);
        chk("g2 seq_len",  32'(bus.seq_len), 4);
        do_guess(4'b0001);
        chk("idle guess ignored", 32'(bus.match), 0);
        chk("idle guess ignored mm", 32'(bus.mismatch), 0);

        // guess round with seq_len 3
        do_new_game(1'b0);
        do_extend(); do_extend();
        chk("r3 seq_len", 32'(bus.seq_len), 3);
        do_play();
        for (int i = 0; i < 3; i++) do_tick();
        chk("r3 done", 32'(bus.play_done), 1);
        for (int i = 0; i < 3; i++) begin
            do_guess(4'b0001);
            chk("r3 match", 32'(bus.match), 1);
            chk("r3 rdone", 32'(bus.round_done), (i == 2) ? 1 : 0);
        end
        cyc();
        quiet();
        // back in IDLE: play is accepted again; multi-bit guess mismatches
        do_play();
        chk("r3 replay busy", 32'(bus.play_busy), 1);
        for (int i = 0; i < 3; i++) do_tick();
        do_guess(4'b0011);
        chk("multi mismatch", 32'(bus.mismatch), 1);
        chk("multi match",    32'(bus.match), 0);
        chk("multi seq_len",  32'(bus.seq_len), 3);

        // fixed fill to full
        do_new_game(1'b0);
        for (int i = 0; i < 20; i++) do_extend();
        chk("fix full len", 32'(bus.seq_len), 16);
        chk("fix full",     32'(bus.full), 1);

        // random fill: expected colour is the model LFSR at the sampling edge
        expc[0] = m_lfsr[1:0];
        do_new_game(1'b1);
        chk("rnd full clr", 32'(bus.full), 0);
        for (int i = 1; i < 20; i++) begin
            if (i < 16) expc[i] = m_lfsr[1:0];
            do_extend();
            if (i == 14) chk("rnd not full", 32'(bus.full), 0);
        end
        chk("rnd len",  32'(bus.seq_len), 16);
        chk("rnd full", 32'(bus.full), 1);
        // extend with play in the same cycle: play dropped
        bus.extend = 1'b1; bus.play = 1'b1; cyc(); bus.extend = 1'b0; bus.play = 1'b0;
        chk("ext+play busy", 32'(bus.play_busy), 0);
        chk("ext+play len",  32'(bus.seq_len), 16);
        do_play();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rnd color %0d", i), 32'(bus.color_out), 32'(4'b0001 << expc[i]));
            do_tick();
        end
        chk("rnd done",  32'(bus.play_done), 1);
        chk("rnd color off", 32'(bus.color_out), 0);
        for (int i = 0; i < 16; i++) begin
            do_guess(4'b0001 << expc[i]);
            chk("rnd guess", 32'(bus.match), 1);
        end
        chk("rnd rdone", 32'(bus.round_done), 1);

        // async reset mid-PLAY at idx 2
        do_new_game(1'b0);
        for (int i = 0; i < 4; i++) do_extend();
        do_play();
        do_tick(); do_tick();
        chk("pre-rst busy", 32'(bus.play_busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst busy",  32'(bus.play_busy), 0);
        chk("arst color", 32'(bus.color_out), 0);
        chk("arst len",   32'(bus.seq_len), 0);
        chk("arst full",  32'(bus.full), 0);
        quiet();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        do_play();
        chk("len0 play busy", 32'(bus.play_busy), 0);
        do_tick();
        chk("len0 tick color", 32'(bus.color_out), 0);
        chk("len0 tick done",  32'(bus.play_done), 0);
        chk("len0 seq_len",    32'(bus.seq_len), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
